// File: rtl/semaforo_pkg.sv
// Shared types and default timing for the two-road traffic-light controller.
package semaforo_pkg;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    RED_AB   = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    RED_BA   = 3'd5
  } estado_t;

  localparam int TICK_DIV_DEF  = 1;
  localparam int GREEN_MIN_DEF = 5;
  localparam int GREEN_MAX_DEF = 12;
  localparam int YELLOW_T_DEF  = 3;
  localparam int ALLRED_T_DEF  = 1;

  // Increment that sticks at 15 so the display never wraps.
  function automatic logic [3:0] satInc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/semaforo_grande_if.sv
// Board-side signal bundle: sensors and push-buttons in, lamps and debug out.
// There is no valid/ready handshake: inputs are levels sampled on every
// clock edge, and every output is a register that is valid on every cycle
// from the first reset edge onward.
interface semaforo_grande_if;
  import semaforo_pkg::*;

  logic       SensorA;
  logic       SensorB;
  logic       PasoA;
  logic       PasoB;
  logic       VerdeA;
  logic       VerdeB;
  logic       AmarilloA;
  logic       AmarilloB;
  logic       RojoA;
  logic       RojoB;
  logic [3:0] cuenta;
  estado_t    estado;

  // Board / environment side.
  modport master (
    output SensorA, SensorB, PasoA, PasoB,
    input  VerdeA, VerdeB, AmarilloA, AmarilloB, RojoA, RojoB, cuenta, estado
  );

  // Controller side.
  modport slave (
    input  SensorA, SensorB, PasoA, PasoB,
    output VerdeA, VerdeB, AmarilloA, AmarilloB, RojoA, RojoB, cuenta, estado
  );

endinterface

// File: rtl/semaforo_tick.sv
// Prescaler: one-cycle tick strobe every TICK_DIV clocks.
module semaforo_tick #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  // Free-running divider, wraps after the last count of the period.
  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/semaforo_grande.sv
// Two-road traffic-light controller: road A is the rest state, road B is
// served on demand (vehicle sensor or latched pedestrian request).
module semaforo_grande
  import semaforo_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int GREEN_MIN = GREEN_MIN_DEF,
  parameter int GREEN_MAX = GREEN_MAX_DEF,
  parameter int YELLOW_T  = YELLOW_T_DEF,
  parameter int ALLRED_T  = ALLRED_T_DEF
) (
  input logic               clk,
  input logic               rst,
  semaforo_grande_if.slave  bus
);

  // Thresholds expressed as the cuenta value seen on the exiting tick.
  localparam logic [3:0] G_MIN_LAST = 4'(GREEN_MIN - 1);
  localparam logic [3:0] G_MAX_LAST = 4'(GREEN_MAX - 1);
  localparam logic [3:0] Y_LAST     = 4'(YELLOW_T - 1);
  localparam logic [3:0] R_LAST     = 4'(ALLRED_T - 1);

  // Lamp vector order: {VerdeA, AmarilloA, RojoA, VerdeB, AmarilloB, RojoB}.
  localparam logic [5:0] LAMPS_RESET = 6'b100_001;

  estado_t    state;
  estado_t    stateNext;
  logic [3:0] cuenta;
  logic       pendA;
  logic       pendB;
  logic       tick;
  logic       reqA;
  logic       reqB;
  logic       change;
  logic [5:0] lamps;
  logic [5:0] lampsNext;

  semaforo_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign reqA   = bus.SensorA | pendB;
  assign reqB   = bus.SensorB | pendA;
  assign change = (stateNext != state);

  // Next-state logic; transitions only happen on tick cycles.
  always_comb begin
    stateNext = state;
    if (tick) begin
      case (state)
        A_GREEN:
          if ((cuenta >= G_MIN_LAST) && reqB &&
              (!bus.SensorA || pendA || (cuenta >= G_MAX_LAST)))
            stateNext = A_YELLOW;
        A_YELLOW: if (cuenta >= Y_LAST) stateNext = RED_AB;
        RED_AB:   if (cuenta >= R_LAST) stateNext = B_GREEN;
        // Road B is released early when nothing is asking for it.
        B_GREEN:
          if ((cuenta >= G_MIN_LAST) &&
              (!reqB || (reqA && (!bus.SensorB || pendB || (cuenta >= G_MAX_LAST)))))
            stateNext = B_YELLOW;
        B_YELLOW: if (cuenta >= Y_LAST) stateNext = RED_BA;
        RED_BA:   if (cuenta >= R_LAST) stateNext = A_GREEN;
        default:  stateNext = A_GREEN;
      endcase
    end
  end

  // Lamp decode from the state being entered, so lamps register with state.
  always_comb begin
    lampsNext = LAMPS_RESET;
    case (stateNext)
      A_GREEN:  lampsNext = 6'b100_001;
      A_YELLOW: lampsNext = 6'b010_001;
      RED_AB:   lampsNext = 6'b001_001;
      B_GREEN:  lampsNext = 6'b001_100;
      B_YELLOW: lampsNext = 6'b001_010;
      RED_BA:   lampsNext = 6'b001_001;
      default:  lampsNext = LAMPS_RESET;
    endcase
  end

  // State, dwell counter and registered lamps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= A_GREEN;
      cuenta <= 4'd0;
      lamps  <= LAMPS_RESET;
    end else begin
      state <= stateNext;
      lamps <= lampsNext;
      if (tick) cuenta <= change ? 4'd0 : satInc(cuenta);
    end
  end

  // Pedestrian latches: a new press in the clearing cycle is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      pendA <= 1'b0;
      pendB <= 1'b0;
    end else begin
      pendA <= bus.PasoA | (pendA & ~(change && (stateNext == B_GREEN)));
      pendB <= bus.PasoB | (pendB & ~(change && (stateNext == A_GREEN)));
    end
  end

  assign {bus.VerdeA, bus.AmarilloA, bus.RojoA,
          bus.VerdeB, bus.AmarilloB, bus.RojoB} = lamps;
  assign bus.cuenta = cuenta;
  assign bus.estado = state;

endmodule

// File: tb/tb_semaforo_grande.sv
// Bench for semaforo_grande: directed scenarios plus random traffic, checked
// against a phase/elapsed-time model through an expected-value queue.
module tb_semaforo_grande;
  import semaforo_pkg::*;

  localparam int GMIN = 5;
  localparam int GMAX = 12;
  localparam int YEL  = 3;
  localparam int AR   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  semaforo_grande_if bus();

  semaforo_grande dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // {VerdeA, AmarilloA, RojoA, VerdeB, AmarilloB, RojoB, cuenta}
  logic [9:0] exp_q[$];

  // ---------------- reference model ----------------
  // Phases in road order: 0 A green, 1 A yellow, 2 red->B, 3 B green,
  // 4 B yellow, 5 red->A. Time in a phase is counted as ticks elapsed.
  int mPhase = 0;
  int mCnt   = 0;
  bit mPendA = 0;
  bit mPendB = 0;
  logic [5:0] lampTab [6] = '{6'b100001, 6'b010001, 6'b001001,
                              6'b001100, 6'b001010, 6'b001001};

  task automatic modelStep();
    int  elapsed;
    bit  leave;
    bit  rA;
    bit  rB;
    bit  nA;
    bit  nB;
    if (rst) begin
      mPhase = 0;
      mCnt   = 0;
      mPendA = 0;
      mPendB = 0;
    end else begin
      elapsed = mCnt + 1;
      rA = bus.SensorA | mPendB;
      rB = bus.SensorB | mPendA;
      leave = 0;
      case (mPhase)
        0: leave = (elapsed >= GMIN) && rB && (!bus.SensorA || mPendA || elapsed >= GMAX);
        1, 4: leave = (elapsed >= YEL);
        2, 5: leave = (elapsed >= AR);
        3: leave = (elapsed >= GMIN) && (!rB || (rA && (!bus.SensorB || mPendB || elapsed >= GMAX)));
        default: leave = 0;
      endcase
      nA = bus.PasoA | (mPendA & !(leave && mPhase == 2));
      nB = bus.PasoB | (mPendB & !(leave && mPhase == 5));
      mPendA = nA;
      mPendB = nB;
      if (leave) begin
        mPhase = (mPhase + 1) % 6;
        mCnt   = 0;
      end else begin
        mCnt = (mCnt >= 15) ? 15 : mCnt + 1;
      end
    end
    exp_q.push_back({lampTab[mPhase], 4'(mCnt)});
  endtask

  // ---------------- driver ----------------
  // Inputs change 2 time units after the edge; the model predicts the
  // outputs that the next edge must produce.
  task automatic drive(input bit r, input bit sa, input bit sb, input bit pa, input bit pb);
    @(posedge clk);
    #2;
    rst         = r;
    bus.SensorA = sa;
    bus.SensorB = sb;
    bus.PasoA   = pa;
    bus.PasoB   = pb;
    modelStep();
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    logic [9:0] act;
    logic [9:0] exp;
    #1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {bus.VerdeA, bus.AmarilloA, bus.RojoA,
             bus.VerdeB, bus.AmarilloB, bus.RojoB, bus.cuenta};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL lamps_cuenta t=%0t got lamps=%b cuenta=%0d want lamps=%b cuenta=%0d",
                 $time, act[9:4], act[3:0], exp[9:4], exp[3:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit sa;
    bit sb;
    bus.SensorA = 0;
    bus.SensorB = 0;
    bus.PasoA   = 0;
    bus.PasoB   = 0;

    // Reset held for two edges.
    doReset(2);

    // Main road busy, nobody else: A green held, cuenta saturates.
    for (int i = 0; i < 35; i++) drive(0, 1, 0, 0, 0);

    // Only road B demands: minimum green then yellow, all-red, B green.
    doReset(2);
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 0, 0);

    // Both roads busy: each green runs to its maximum.
    doReset(2);
    for (int i = 0; i < 45; i++) drive(0, 1, 1, 0, 0);

    // Pedestrian pulse on A one cycle after reset release.
    doReset(2);
    for (int i = 0; i < 30; i++) drive(0, 1, 0, (i == 1), 0);

    // Reset asserted for one cycle while B is yellow.
    doReset(2);
    for (int i = 0; i < 60; i++) begin
      if (mPhase == 4) break;
      drive(0, 0, (mPhase != 3), 0, 0);
    end
    drive(1, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);

    // Random traffic with occasional presses and resets.
    sa = 0;
    sb = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) sa = ~sa;
      if ($urandom_range(0, 15) == 0) sb = ~sb;
      drive(($urandom_range(0, 199) == 0), sa, sb,
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0));
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/semaforo_grande.md
Name: semaforo_grande

Overview:
- Two-road intersection traffic-light controller (road A = main, road B = secondary) with vehicle sensors and pedestrian push-buttons per road.
- Cycles Green → Yellow → All-Red for each road in turn, driven by a prescaled timing tick.
- Exposes the in-state elapsed-tick count for display/debug.
- Top-level control block: inputs come from debounced board buttons/switches; outputs drive lamp LEDs directly.

Parameters:
- TICK_DIV, 1, clock cycles per timing tick (1 = every clock; set to the clock frequency for 1 s ticks on hardware).
- GREEN_MIN, 5, minimum green dwell in ticks (1..15).
- GREEN_MAX, 12, maximum green extension in ticks while a conflicting request is pending (GREEN_MIN..15).
- YELLOW_T, 3, yellow dwell in ticks (1..15).
- ALLRED_T, 1, all-red clearance dwell in ticks (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- SensorA  in  1  vehicle present on road A (level).
- SensorB  in  1  vehicle present on road B (level).
- PasoA  in  1  pedestrian request to cross road A (pulse or level; latched).
- PasoB  in  1  pedestrian request to cross road B (latched).
- VerdeA  out  1  road A green lamp.
- VerdeB  out  1  road B green lamp.
- AmarilloA  out  1  road A yellow lamp.
- AmarilloB  out  1  road B yellow lamp.
- RojoA  out  1  road A red lamp.
- RojoB  out  1  road B red lamp.
- cuenta  out  4  ticks elapsed in the current state; saturates at 15.

Behaviour:
- States: A_GREEN, A_YELLOW, RED_AB (all red, next B), B_GREEN, B_YELLOW, RED_BA (all red, next A).
- Lamps are decoded from state, registered outputs. Exactly one lamp is on per road at all times.
  - A_GREEN: VerdeA, RojoB.
  - A_YELLOW: AmarilloA, RojoB.
  - RED_AB / RED_BA: RojoA, RojoB.
  - B_GREEN: RojoA, VerdeB.
  - B_YELLOW: RojoA, AmarilloB.
- Reset (rst=1 at a clk edge): state=A_GREEN, cuenta=0, tick prescaler=0, pending latches cleared. Outputs are VerdeA=1 and RojoB=1, all other lamps 0. rst overrides all other inputs.
- Tick: one-cycle strobe every TICK_DIV clocks. State and cuenta change only on tick cycles.
- cuenta: on a tick, returns to 0 on a state change; otherwise increments, saturating at 15.
- Pending latches:
  - pendA is set by PasoA and cleared on entry to B_GREEN.
  - pendB is set by PasoB and cleared on entry to A_GREEN.
  - Set and clear in the same cycle: set wins.
- Request for B: reqB = SensorB | pendA. Request for A: reqA = SensorA | pendB.
- A_GREEN exits to A_YELLOW on a tick when cuenta ≥ GREEN_MIN-1 and reqB, and one of the following holds: !SensorA, pendA, or cuenta ≥ GREEN_MAX-1. With no reqB it stays in A_GREEN indefinitely.
- B_GREEN is symmetric with A/B swapped, with one difference: it also exits when !reqB, i.e. road B is not held without demand. This makes road A the rest state.
- Yellow exits after YELLOW_T ticks (on the tick where cuenta = YELLOW_T-1). All-red exits after ALLRED_T ticks.
- Latency: a request arriving while in A_GREEN with cuenta ≥ GREEN_MIN-1 and SensorA=0 reaches A_YELLOW on the next tick.
- Simultaneous reqA and reqB during all-red is irrelevant; the sequence is fixed A→B→A.
- Reset mid-cycle (any state) returns to A_GREEN on the next edge.

Decomposition:
- Package semaforo_pkg: state enum (6 states, 3-bit encoding), default timing constants.
- Sub-module semaforo_tick: prescaler producing the tick strobe from TICK_DIV, with synchronous rst.
- FSM, latches and lamp decode stay in semaforo_grande.

Test Plan (TICK_DIV=1, default timings):
- Hold rst=1 for 2 edges → VerdeA=1, RojoB=1, the other four lamps 0, cuenta=0.
- Release rst with SensorA=1 and all other inputs 0 → A_GREEN held for 30+ cycles; cuenta counts 0..15 and stays at 15; lamps unchanged.
- SensorA=0, SensorB=1 from reset → A_GREEN for 5 cycles (cuenta 0..4), A_YELLOW for 3 cycles, RED_AB for 1 cycle, then B_GREEN with VerdeB=1 and RojoA=1.
- SensorA=1, SensorB=1 → A_GREEN for 12 cycles (GREEN_MAX), then yellow. B_GREEN likewise lasts 12 cycles before returning to A.
- SensorA=1, single-cycle PasoA pulse at cycle 1 → A_GREEN exits after 5 cycles. B_GREEN lasts 5 cycles, then returns to A; pendA is 0 after B_GREEN entry.
- Assert rst for 1 cycle during B_YELLOW → next edge shows VerdeA=1, RojoB=1, cuenta=0.
